// File: rtl/mode_key_ctrl.sv
// Digital-clock button front end: per-key sync/debounce, major/minor mode
// state, increase pulses with auto-repeat, and an inactivity return to mode2=0.

// One key lane: 2-FF synchronizer followed by a debounce counter.
module mode_key_deb #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], key_raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module mode_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int M2_LAST         = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_mode,
  input  logic       key_set,
  input  logic       key_inc,
  output logic [1:0] mode1,
  output logic [1:0] mode2,
  output logic       increase
);
  localparam int NUM_KEYS = 3;
  localparam int K_MODE   = 0;
  localparam int K_SET    = 1;
  localparam int K_INC    = 2;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW       = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam int TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [1:0] M2_TOP = 2'(M2_LAST);

  logic [NUM_KEYS-1:0] key_raw, key_lvl, key_lvl_d, key_press;
  logic p_mode, p_set, p_inc, inc_lvl, rep_start;

  logic [1:0]    mode1_nx, mode2_nx;
  logic          inc_nx;
  logic          rep_en, rep_en_nx, rep_first, rep_first_nx;
  logic [HW-1:0] hold_cnt, hold_nx, hold_tgt;
  logic [TW-1:0] tout_cnt, tout_nx;

  assign key_raw = {key_inc, key_set, key_mode};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    mode_key_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .key_raw (key_raw[i]),
      .level   (key_lvl[i])
    );
  end

  assign key_press = key_lvl & ~key_lvl_d;
  assign p_mode    = key_press[K_MODE];
  assign p_set     = key_press[K_SET];
  assign p_inc     = key_press[K_INC];
  assign inc_lvl   = key_lvl[K_INC];
  // INC only starts a burst when it is the sole press and a field is selected.
  assign rep_start = p_inc & ~p_mode & ~p_set & (mode2 != 2'd0);
  assign hold_tgt  = rep_first ? HW'(REPEAT_DELAY - 1) : HW'(REPEAT_PERIOD - 1);

  // Next-state: press-driven mode changes, increase/repeat, then timeout.
  always_comb begin
    mode1_nx     = mode1;
    mode2_nx     = mode2;
    inc_nx       = 1'b0;
    rep_en_nx    = rep_en;
    rep_first_nx = rep_first;
    hold_nx      = hold_cnt;
    tout_nx      = tout_cnt;

    if (p_mode) begin
      mode1_nx  = mode1 + 2'd1;
      mode2_nx  = 2'd0;
      rep_en_nx = 1'b0;
    end else if (p_set) begin
      mode2_nx = (mode2 == M2_TOP) ? 2'd0 : mode2 + 2'd1;
    end

    if (rep_start) begin
      inc_nx       = 1'b1;
      rep_en_nx    = 1'b1;
      rep_first_nx = 1'b1;
      hold_nx      = '0;
    end else if (rep_en && !p_mode && inc_lvl && mode2_nx != 2'd0) begin
      if (hold_cnt == hold_tgt) begin
        inc_nx       = 1'b1;
        rep_first_nx = 1'b0;
        hold_nx      = '0;
      end else begin
        hold_nx = hold_cnt + HW'(1);
      end
    end

    // Any activity restarts the inactivity window.
    if ((|key_press) || inc_nx) begin
      tout_nx = '0;
    end else if (mode2 != 2'd0) begin
      if (tout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        mode2_nx = 2'd0;
        tout_nx  = '0;
      end else begin
        tout_nx = tout_cnt + TW'(1);
      end
    end else begin
      tout_nx = '0;
    end

    // Release or leaving field-set mode ends the burst immediately.
    if (!inc_lvl || mode2_nx == 2'd0) begin
      rep_en_nx = 1'b0;
      hold_nx   = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode1     <= '0;
      mode2     <= '0;
      increase  <= 1'b0;
      rep_en    <= 1'b0;
      rep_first <= 1'b0;
      hold_cnt  <= '0;
      tout_cnt  <= '0;
      key_lvl_d <= '0;
    end else begin
      mode1     <= mode1_nx;
      mode2     <= mode2_nx;
      increase  <= inc_nx;
      rep_en    <= rep_en_nx;
      rep_first <= rep_first_nx;
      hold_cnt  <= hold_nx;
      tout_cnt  <= tout_nx;
      key_lvl_d <= key_lvl;
    end
  end
endmodule

// File: tb/tb_mode_key_ctrl.sv
// Bench for mode_key_ctrl: directed scenarios plus random key traffic, every
// cycle checked against a timestamp-based reference model.
module tb_mode_key_ctrl;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int TO = 64;
  localparam int ML = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_mode = 1'b0, key_set = 1'b0, key_inc = 1'b0;
  logic [1:0] mode1, mode2;
  logic       increase;

  mode_key_ctrl #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .TIMEOUT_CYCLES(TO), .M2_LAST(ML)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_mode (key_mode),
    .key_set  (key_set),
    .key_inc  (key_inc),
    .mode1    (mode1),
    .mode2    (mode2),
    .increase (increase)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int pulse_cnt = 0, t_pulse = 0, t_rise = 0, t_fall = 0, prev_m2 = 0;

  // Reference model: raw samples and debounced levels indexed by edge since reset.
  bit [2:0] raw_q[$];
  bit [2:0] lvl_q[$];
  int m1 = 0, m2 = 0, next_rep = 0, last_act = 0;
  bit rep = 1'b0, exp_inc = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic bit [2:0] raw_at(input int i);
    if (i < 0) return 3'b000;
    return raw_q[i];
  endfunction

  function automatic bit [2:0] lvl_at(input int i);
    if (i < 0) return 3'b000;
    return lvl_q[i];
  endfunction

  task automatic model_reset();
    raw_q.delete();
    lvl_q.delete();
    m1 = 0; m2 = 0; rep = 1'b0; exp_inc = 1'b0; last_act = 0; next_rep = 0;
    prev_m2 = 0;
  endtask

  // Level flips when the D most recent synchronized samples all disagree with it;
  // a press is the cycle after the level rose.
  task automatic model_edge(input bit [2:0] raw);
    int e, m2_before;
    bit [2:0] cur, nxt, win, lm1, lm2, prs;
    bit all_diff, il, pulse;
    e = raw_q.size();
    raw_q.push_back(raw);
    cur = lvl_at(e - 1);
    nxt = cur;
    for (int b = 0; b < 3; b++) begin
      all_diff = 1'b1;
      for (int j = e - 1 - D; j <= e - 2; j++) begin
        win = raw_at(j);
        if (win[b] == cur[b]) all_diff = 1'b0;
      end
      if (all_diff) nxt[b] = ~cur[b];
    end
    lvl_q.push_back(nxt);
    lm1 = lvl_at(e - 1);
    lm2 = lvl_at(e - 2);
    prs = lm1 & ~lm2;
    il  = lm1[2];
    m2_before = m2;
    pulse = 1'b0;
    if (prs[0]) begin
      m1 = (m1 + 1) % 4; m2 = 0; rep = 1'b0;
    end else if (prs[1]) begin
      m2 = (m2 == ML) ? 0 : m2 + 1;
    end
    if (prs[2] && !prs[0] && !prs[1] && m2_before != 0) begin
      pulse = 1'b1; rep = 1'b1; next_rep = e + RD;
    end else if (rep && il && m2 != 0 && e == next_rep) begin
      pulse = 1'b1; next_rep = e + RP;
    end
    if (prs != 3'b000 || pulse) last_act = e;
    else if (m2 != 0 && e - last_act == TO) begin
      m2 = 0; last_act = e;
    end
    if (!il || m2 == 0) rep = 1'b0;
    exp_inc = pulse;
  endtask

  // Drive at a falling edge, advance one rising edge, check at the next falling edge.
  task automatic step(input bit km, input bit ks, input bit ki);
    key_mode = km; key_set = ks; key_inc = ki;
    @(posedge clk);
    model_edge({ki, ks, km});
    @(negedge clk);
    cyc++;
    chk("mode1", int'(mode1), m1);
    chk("mode2", int'(mode2), m2);
    chk("increase", int'(increase), int'(exp_inc));
    if (increase) begin pulse_cnt++; t_pulse = cyc; end
    if (prev_m2 == 0 && mode2 != 2'd0) t_rise = cyc;
    if (prev_m2 != 0 && mode2 == 2'd0) t_fall = cyc;
    prev_m2 = int'(mode2);
  endtask

  task automatic hold(input bit km, input bit ks, input bit ki, input int n);
    repeat (n) step(km, ks, ki);
  endtask

  task automatic press(input bit km, input bit ks, input bit ki);
    hold(km, ks, ki, 8);
    hold(1'b0, 1'b0, 1'b0, 8);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset(input int n);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mode1", int'(mode1), 0);
    chk("rst_mode2", int'(mode2), 0);
    chk("rst_increase", int'(increase), 0);
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int lat, guard, len;
    bit km, ks, ki;
    repeat (3) @(negedge clk);
    chk("init_mode1", int'(mode1), 0);
    chk("init_mode2", int'(mode2), 0);
    chk("init_increase", int'(increase), 0);
    reset_n = 1'b1;
    model_reset();

    // Short glitch ignored, then a real press with measured latency.
    hold(1'b1, 1'b0, 1'b0, 3);
    hold(1'b0, 1'b0, 1'b0, 10);
    chk("glitch_mode1", int'(mode1), 0);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (lat < 0 && mode1 == 2'd1) lat = i - 1;
    end
    hold(1'b0, 1'b0, 1'b0, 10);
    chk("press_latency", lat, 6);
    chk("single_step", int'(mode1), 1);

    // Mode cycling and SET wrap.
    repeat (4) press(1'b1, 1'b0, 1'b0);
    chk("mode_cycle", int'(mode1), 1);
    repeat (3) press(1'b0, 1'b1, 1'b0);
    chk("set_wrap", int'(mode2), 0);
    repeat (2) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("mode_clears_m2", int'(mode2), 0);
    chk("mode_after_m2", int'(mode1), 2);

    // Auto-repeat with a field selected, then with mode2 = 0.
    press(1'b0, 1'b1, 1'b0);
    pulse_cnt = 0;
    hold(1'b0, 1'b0, 1'b1, 30);
    hold(1'b0, 1'b0, 1'b0, 12);
    chk("rep_pulses", pulse_cnt, 7);
    press(1'b1, 1'b0, 1'b0);
    pulse_cnt = 0;
    hold(1'b0, 1'b0, 1'b1, 30);
    hold(1'b0, 1'b0, 1'b0, 12);
    chk("rep_m2_zero", pulse_cnt, 0);

    // MODE and INC in the same cycle.
    press(1'b0, 1'b1, 1'b0);
    pulse_cnt = 0;
    hold(1'b1, 1'b0, 1'b1, 30);
    hold(1'b0, 1'b0, 1'b0, 12);
    chk("simul_pulses", pulse_cnt, 0);
    chk("simul_mode1", int'(mode1), 0);
    chk("simul_mode2", int'(mode2), 0);

    // Inactivity timeout, then a pulse at cycle 50 restarting it.
    hold(1'b0, 1'b1, 1'b0, 8);
    hold(1'b0, 1'b0, 1'b0, 80);
    chk("timeout", t_fall - t_rise, 64);
    hold(1'b0, 1'b1, 1'b0, 8);
    guard = 0;
    while ((cyc - t_rise < 43) && (guard < 100)) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    hold(1'b0, 1'b0, 1'b1, 8);
    hold(1'b0, 1'b0, 1'b0, 80);
    chk("tout_pulse_at", t_pulse - t_rise, 50);
    chk("tout_restart", t_fall - t_pulse, 64);

    // Reset mid-repeat and mid-debounce; a key held through release is a fresh press.
    press(1'b0, 1'b1, 1'b0);
    hold(1'b0, 1'b0, 1'b1, 15);
    hold(1'b1, 1'b0, 1'b1, 2);
    do_reset(2);
    hold(1'b1, 1'b0, 1'b1, 10);
    chk("post_rst_mode1", int'(mode1), 1);
    hold(1'b0, 1'b0, 1'b0, 20);

    // Random traffic including chatter and occasional resets.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int c = 0; c < 12; c++)
          step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        km  = ($urandom_range(0, 5) == 0);
        ks  = ($urandom_range(0, 2) == 0);
        ki  = ($urandom_range(0, 1) == 0);
        len = $urandom_range(1, 36);
        hold(km, ks, ki, len);
      end
      hold(1'b0, 1'b0, 1'b0, $urandom_range(0, 70));
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
